ped_signal_ctrl: RTL and testbench

Pedestrian crossing signal controller that sits directly downstream of the traffic light controller. It consumes the one-hot vehicle light bus and latches pedestrian requests. When the vehicle light turns RED, it runs a timed WALK phase and then a flashing DON'T-WALK clearance phase. It aborts to a safe DON'T-WALK state whenever the vehicle light is not RED, or when the light code is illegal.

---
 rtl/ped_signal_ctrl_if.sv | 27 ++
 rtl/ped_signal_ctrl.sv | 119 +++++++++++
 tb/tb_ped_signal_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ped_signal_ctrl_if.sv
// Pedestrian signal bus: vehicle light and button in, lamps and status out.
// master drives the light/button side; slave is the controller.
interface ped_signal_ctrl_if #(
    parameter int CNT_W = 4
);
    logic [0:2]       light;
    logic             ped_req;
    logic             walk;
    logic             dont_walk;
    logic             flash;
    logic [CNT_W-1:0] countdown;
    logic             req_pending;
    logic             abort;
    logic             light_err;

    modport master (
        output light, ped_req,
        input  walk, dont_walk, flash, countdown,
        input  req_pending, abort, light_err
    );

    modport slave (
        input  light, ped_req,
        output walk, dont_walk, flash, countdown,
        output req_pending, abort, light_err
    );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: timed WALK then flashing clearance
// on vehicle red onset, safe abort on non-red or illegal light codes.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ped_signal_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        WALK,
        FLASH
    } state_t;

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n;
    logic             flash_n;
    logic             req_n;
    logic             abort_n;
    logic             err_n;
    logic             prev_red;
    logic             red;
    logic             legal;
    logic             onset;

    assign red   = (bus.light == 3'b100);
    assign legal = red || (bus.light == 3'b010) || (bus.light == 3'b001);
    assign onset = red && !prev_red;

    always_comb begin
        state_n = state;
        cnt_n   = bus.countdown;
        flash_n = 1'b0;
        req_n   = bus.req_pending | bus.ped_req;
        abort_n = 1'b0;
        err_n   = 1'b0;
        if (!legal) begin
            state_n = IDLE;
            cnt_n   = '0;
            err_n   = 1'b1;
            if (state != IDLE) begin
                abort_n = 1'b1;
                req_n   = 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (onset && req_n) begin
                        state_n = WALK;
                        cnt_n   = WALK_LOAD;
                        req_n   = 1'b0;
                    end
                end
                WALK: begin
                    if (!red) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        abort_n = 1'b1;
                        req_n   = 1'b1;
                    end else if (bus.countdown == '0) begin
                        state_n = FLASH;
                        cnt_n   = FLASH_LOAD;
                        flash_n = 1'b1;
                    end else begin
                        cnt_n = bus.countdown - 1'b1;
                    end
                end
                FLASH: begin
                    if (!red) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        abort_n = 1'b1;
                        req_n   = 1'b1;
                    end else if (bus.countdown == '0) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = bus.countdown - 1'b1;
                        flash_n = !bus.flash;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Lamps are registered from the next state so outputs stay Moore.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            prev_red        <= 1'b0;
            bus.walk        <= 1'b0;
            bus.dont_walk   <= 1'b1;
            bus.flash       <= 1'b0;
            bus.countdown   <= '0;
            bus.req_pending <= 1'b0;
            bus.abort       <= 1'b0;
            bus.light_err   <= 1'b0;
        end else begin
            state           <= state_n;
            prev_red        <= red;
            bus.walk        <= (state_n == WALK);
            bus.dont_walk   <= (state_n != WALK);
            bus.flash       <= flash_n;
            bus.countdown   <= cnt_n;
            bus.req_pending <= req_n;
            bus.abort       <= abort_n;
            bus.light_err   <= err_n;
        end
    end
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Randomized and directed bench for ped_signal_ctrl against a
// phase-time reference model.
module tb_ped_signal_ctrl;
    localparam int W     = 8;
    localparam int F     = 4;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ped_signal_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ped_signal_ctrl #(
        .WALK_CYCLES (W),
        .FLASH_CYCLES(F),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a served phase is a tick index t in 0..W+F-1.
    bit m_act;
    int m_t;
    bit m_pend;
    bit m_prev;
    bit m_abort;
    bit m_err;

    function automatic logic [9:0] exp_vec();
        logic w;
        logic fl;
        int   cd;
        w  = m_act && (m_t < W);
        fl = m_act && (m_t >= W) && (((m_t - W) % 2) == 0);
        if (!m_act)     cd = 0;
        else if (m_t < W) cd = W - 1 - m_t;
        else            cd = W + F - 1 - m_t;
        return {w, !w, fl, 4'(cd), m_pend, m_abort, m_err};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {bus.walk, bus.dont_walk, bus.flash, bus.countdown,
                bus.req_pending, bus.abort, bus.light_err};
    endfunction

    task automatic model_reset();
        m_act = 0; m_t = 0; m_pend = 0;
        m_prev = 0; m_abort = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [0:2] l, input bit p);
        bit ill;
        bit red;
        red = (l == 3'b100);
        ill = !(red || l == 3'b010 || l == 3'b001);
        m_abort = 0;
        m_err   = 0;
        if (ill) begin
            m_err   = 1;
            m_abort = m_act;
            m_pend  = m_act ? 1'b1 : (m_pend | p);
            m_act   = 0;
        end else if (m_act && !red) begin
            m_abort = 1;
            m_pend  = 1;
            m_act   = 0;
        end else if (m_act) begin
            m_t++;
            if (m_t == W + F) m_act = 0;
            m_pend = m_pend | p;
        end else if (red && !m_prev && (m_pend || p)) begin
            m_act  = 1;
            m_t    = 0;
            m_pend = 0;
        end else begin
            m_pend = m_pend | p;
        end
        m_prev = red;
    endtask

    task automatic step(input logic [0:2] l, input bit p);
        bus.light   = l;
        bus.ped_req = p;
        @(posedge clk);
        model_step(l, p);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", dut_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_red();
        for (int i = 0; i < 6; i++) begin
            step(3'b100, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec() || bus.walk !== 1'b0) begin
                failures++;
                $display("FAIL idle_red[%0d] got=%h exp=%h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_served();
        step(3'b010, 1'b1);
        for (int i = 0; i < 22; i++) begin
            step(i == 0 ? 3'b010 : 3'b100, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL served[%0d] got=%h exp=%h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_req_onset();
        bit rose;
        rose = 0;
        step(3'b010, 1'b0);
        step(3'b100, 1'b1);
        checks++;
        if (bus.walk !== 1'b1 || bus.countdown !== 4'(W - 1)) begin
            failures++;
            $display("FAIL req_onset_start got=%b/%0d exp=1/%0d",
                     bus.walk, bus.countdown, W - 1);
        end
        for (int i = 0; i < 14; i++) begin
            if (bus.req_pending) rose = 1;
            step(3'b100, 1'b0);
            if (bus.req_pending) rose = 1;
        end
        checks++;
        if (rose || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL req_onset got=%h rose=%b exp=%h",
                     dut_vec(), rose, exp_vec());
        end
    endtask

    task automatic test_abort();
        step(3'b010, 1'b1);
        step(3'b100, 1'b0);
        while (m_act && m_t < 4) step(3'b100, 1'b0);
        checks++;
        if (bus.countdown !== 4'd3) begin
            failures++;
            $display("FAIL abort_pre got=%0d exp=3", bus.countdown);
        end
        step(3'b010, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec() || bus.abort !== 1'b1 ||
            bus.walk !== 1'b0 || bus.req_pending !== 1'b1) begin
            failures++;
            $display("FAIL abort got=%h exp=%h", dut_vec(), exp_vec());
        end
        step(3'b010, 1'b0);
        checks++;
        if (bus.abort !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse got=%b exp=0", bus.abort);
        end
        for (int i = 0; i < 14; i++) begin
            step(3'b100, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_reserve[%0d] got=%h exp=%h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flash_req();
        step(3'b010, 1'b1);
        for (int i = 0; i < 18; i++) begin
            step(3'b100, (i == W + 1) ? 1'b1 : 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL flash_req[%0d] got=%h exp=%h",
                         i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.walk !== 1'b0 || bus.req_pending !== 1'b1) begin
            failures++;
            $display("FAIL flash_hold got=%b/%b exp=0/1",
                     bus.walk, bus.req_pending);
        end
        step(3'b001, 1'b0);
        step(3'b100, 1'b0);
        checks++;
        if (bus.walk !== 1'b1 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL flash_next got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_illegal();
        step(3'b010, 1'b0);
        while (m_act) step(3'b010, 1'b0);
        step(3'b010, 1'b1);
        step(3'b110, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec() || bus.light_err !== 1'b1 ||
            bus.abort !== 1'b0 || bus.req_pending !== 1'b1) begin
            failures++;
            $display("FAIL illegal_idle got=%h exp=%h", dut_vec(), exp_vec());
        end
        step(3'b100, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec() || bus.walk !== 1'b1) begin
            failures++;
            $display("FAIL illegal_onset got=%h exp=%h", dut_vec(), exp_vec());
        end
        step(3'b100, 1'b0);
        step(3'b111, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec() || bus.abort !== 1'b1) begin
            failures++;
            $display("FAIL illegal_walk got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        step(3'b010, 1'b1);
        step(3'b100, 1'b0);
        step(3'b100, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b100, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_after got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [0:2] l;
        int r;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      l = 3'b100;
            else if (r < 75) l = 3'b010;
            else if (r < 92) l = 3'b001;
            else             l = 3'($urandom_range(0, 7));
            step(l, ($urandom_range(0, 9) == 0));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d] light=%b got=%h exp=%h",
                         i, l, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b1;
        bus.light   = 3'b010;
        bus.ped_req = 1'b0;
        model_reset();
        test_reset();
        test_idle_red();
        test_served();
        test_req_onset();
        test_abort();
        test_flash_req();
        test_illegal();
        test_reset_mid();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
